// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and owner codes.
`ifndef MEM_PORT_ARBITER_PKG_SV
`define MEM_PORT_ARBITER_PKG_SV

package mem_port_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RESPOND = 2'd2
   } arb_state_e;

   // Owner codes as seen on the owner output
   localparam logic OWNER_FETCH = 1'b0;
   localparam logic OWNER_DATA  = 1'b1;

   // Width of an instruction word returned to fetch
   localparam int unsigned FETCH_WIDTH = 32;

endpackage

`endif

// File: rtl/mem_port_arbiter_arb_streak_counter.sv
// Saturating streak counter with increment, clear and limit-reached flag.
module arb_streak_counter #(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_q, count_d;
   logic          at_limit_q, at_limit_d;

   // Clear has priority; increment stops once the limit is reached
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != CW'(LIMIT))) begin
         count_d = count_q + CW'(1);
      end
      at_limit_d = (count_d == CW'(LIMIT));
   end

   // Counter and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         at_limit_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         at_limit_q <= at_limit_d;
      end
   end

   assign at_limit_o = at_limit_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Data wins ties until it has taken MAX_DATA_STREAK grants in a row while
// fetch waits; a hung memory is abandoned after TIMEOUT access cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned TIMEOUT         = 255
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic                   fetchReq,
   input  logic [ADDR_WIDTH-1:0]  fetchAddr,
   output logic                   fetchAck,
   output logic [FETCH_WIDTH-1:0] fetchData,
   input  logic                   dataReq,
   input  logic                   dataWrite,
   input  logic [ADDR_WIDTH-1:0]  dataAddr,
   input  logic [DATA_WIDTH-1:0]  dataWData,
   output logic                   dataAck,
   output logic [DATA_WIDTH-1:0]  dataRData,
   output logic                   busErr,
   output logic                   memEnable,
   output logic                   memWriteEn,
   output logic [ADDR_WIDTH-1:0]  memAddr,
   output logic [DATA_WIDTH-1:0]  memWData,
   input  logic [DATA_WIDTH-1:0]  memRData,
   input  logic                   memReady,
   output logic                   owner,
   output logic                   busy
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   arb_state_e             state_q, state_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   mem_en_q, mem_en_d;
   logic                   busy_q, busy_d;
   logic                   owner_q, owner_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic                   fetch_ack_q, fetch_ack_d;
   logic                   data_ack_q, data_ack_d;
   logic                   bus_err_q, bus_err_d;
   logic [FETCH_WIDTH-1:0] fetch_data_q, fetch_data_d;
   logic [DATA_WIDTH-1:0]  data_rdata_q, data_rdata_d;

   logic grant_data_c;
   logic streak_inc_c;
   logic streak_clr_c;
   logic streak_at_limit;

   arb_streak_counter #(
      .LIMIT (MAX_DATA_STREAK)
   ) u_streak (
      .clk        (clock),
      .rst_n      (resetN),
      .inc_i      (streak_inc_c),
      .clr_i      (streak_clr_c),
      .at_limit_o (streak_at_limit)
   );

   // Next-state, arbitration and response logic
   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      mem_en_d     = mem_en_q;
      busy_d       = busy_q;
      owner_d      = owner_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      fetch_ack_d  = 1'b0;
      data_ack_d   = 1'b0;
      bus_err_d    = 1'b0;
      fetch_data_d = fetch_data_q;
      data_rdata_d = data_rdata_q;
      grant_data_c = 1'b0;
      streak_inc_c = 1'b0;
      streak_clr_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            grant_data_c = dataReq && !(fetchReq && streak_at_limit);
            streak_inc_c = fetchReq && grant_data_c;
            streak_clr_c = !streak_inc_c;
            if (fetchReq || dataReq) begin
               state_d  = ST_ACCESS;
               tmo_d    = '0;
               mem_en_d = 1'b1;
               busy_d   = 1'b1;
               if (grant_data_c) begin
                  owner_d     = OWNER_DATA;
                  mem_we_d    = dataWrite;
                  mem_addr_d  = dataAddr;
                  mem_wdata_d = dataWData;
               end else begin
                  owner_d    = OWNER_FETCH;
                  mem_we_d   = 1'b0;
                  mem_addr_d = fetchAddr;
               end
            end
         end

         ST_ACCESS: begin
            // memReady beats a simultaneous timeout
            if (memReady || (tmo_q == TMO_W'(TIMEOUT - 1))) begin
               state_d   = ST_RESPOND;
               mem_en_d  = 1'b0;
               mem_we_d  = 1'b0;
               bus_err_d = !memReady;
               if (owner_q == OWNER_FETCH) begin
                  fetch_ack_d  = 1'b1;
                  fetch_data_d = memReady ? memRData[FETCH_WIDTH-1:0] : '0;
               end else begin
                  data_ack_d = 1'b1;
                  if (!mem_we_q) begin
                     data_rdata_d = memReady ? memRData : '0;
                  end
               end
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         ST_RESPOND: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tmo_d   = '0;
         end

         default: begin
            state_d  = ST_IDLE;
            mem_en_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State and output registers; an in-flight access is dropped on reset
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ST_IDLE;
         tmo_q        <= '0;
         mem_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         owner_q      <= OWNER_FETCH;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         fetch_ack_q  <= 1'b0;
         data_ack_q   <= 1'b0;
         bus_err_q    <= 1'b0;
         fetch_data_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         mem_en_q     <= mem_en_d;
         busy_q       <= busy_d;
         owner_q      <= owner_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         fetch_ack_q  <= fetch_ack_d;
         data_ack_q   <= data_ack_d;
         bus_err_q    <= bus_err_d;
         fetch_data_q <= fetch_data_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign fetchAck   = fetch_ack_q;
   assign fetchData  = fetch_data_q;
   assign dataAck    = data_ack_q;
   assign dataRData  = data_rdata_q;
   assign busErr     = bus_err_q;
   assign memEnable  = mem_en_q;
   assign memWriteEn = mem_we_q;
   assign memAddr    = mem_addr_q;
   assign memWData   = mem_wdata_q;
   assign owner      = owner_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written
// streak/reset sequences and a randomized run against a transaction model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned AW   = 64;
   localparam int unsigned DW   = 64;
   localparam int unsigned MAXS = 4;
   localparam int unsigned TMO  = 255;

   logic          clock = 1'b0;
   logic          resetN;
   logic          fetchReq;
   logic [AW-1:0] fetchAddr;
   logic          fetchAck;
   logic [31:0]   fetchData;
   logic          dataReq;
   logic          dataWrite;
   logic [AW-1:0] dataAddr;
   logic [DW-1:0] dataWData;
   logic          dataAck;
   logic [DW-1:0] dataRData;
   logic          busErr;
   logic          memEnable;
   logic          memWriteEn;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWData;
   logic [DW-1:0] memRData;
   logic          memReady;
   logic          owner;
   logic          busy;

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_DATA_STREAK (MAXS),
      .TIMEOUT         (TMO)
   ) u_dut (
      .clock      (clock),
      .resetN     (resetN),
      .fetchReq   (fetchReq),
      .fetchAddr  (fetchAddr),
      .fetchAck   (fetchAck),
      .fetchData  (fetchData),
      .dataReq    (dataReq),
      .dataWrite  (dataWrite),
      .dataAddr   (dataAddr),
      .dataWData  (dataWData),
      .dataAck    (dataAck),
      .dataRData  (dataRData),
      .busErr     (busErr),
      .memEnable  (memEnable),
      .memWriteEn (memWriteEn),
      .memAddr    (memAddr),
      .memWData   (memWData),
      .memRData   (memRData),
      .memReady   (memReady),
      .owner      (owner),
      .busy       (busy)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        fr, dr, wr;
      logic [63:0] faddr, daddr, wdata, rdata;
      int          delay;
      logic        e_owner, e_we;
      logic [63:0] e_addr, e_wdata;
      logic [31:0] e_fdata;
      logic [63:0] e_drdata;
      int          e_lat;
      logic        e_berr;
   } tvec_t;

   tvec_t tv[9];

   function automatic tvec_t mk(input logic fr, input logic dr, input logic wr,
                                input logic [63:0] faddr, input logic [63:0] daddr,
                                input logic [63:0] wdata, input logic [63:0] rdata,
                                input int delay, input logic e_owner, input logic e_we,
                                input logic [63:0] e_addr, input logic [63:0] e_wdata,
                                input logic [31:0] e_fdata, input logic [63:0] e_drdata,
                                input int e_lat, input logic e_berr);
      tvec_t v;
      v.fr = fr; v.dr = dr; v.wr = wr;
      v.faddr = faddr; v.daddr = daddr; v.wdata = wdata; v.rdata = rdata;
      v.delay = delay; v.e_owner = e_owner; v.e_we = e_we;
      v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_fdata = e_fdata;
      v.e_drdata = e_drdata; v.e_lat = e_lat; v.e_berr = e_berr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      fetchReq  = 1'b0;
      fetchAddr = '0;
      dataReq   = 1'b0;
      dataWrite = 1'b0;
      dataAddr  = '0;
      dataWData = '0;
      memReady  = 1'b0;
      memRData  = '0;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clock);
      resetN = 1'b1;
   endtask

   // One isolated transaction from IDLE; the bench plays memory with v.delay wait cycles
   task automatic apply_vec(input string tag, input tvec_t v);
      int   k;
      int   acc;
      logic got;
      k = 0; acc = 0; got = 1'b0;
      @(negedge clock);
      fetchReq = v.fr; fetchAddr = v.faddr;
      dataReq = v.dr; dataWrite = v.wr; dataAddr = v.daddr; dataWData = v.wdata;
      memReady = 1'b0; memRData = v.rdata;
      while (!got && k < 600) begin
         @(negedge clock);
         k++;
         if (k == 1) begin
            chk($sformatf("%s memEnable", tag), 64'(memEnable), 64'(1));
            chk($sformatf("%s owner", tag), 64'(owner), 64'(v.e_owner));
            chk($sformatf("%s memWriteEn", tag), 64'(memWriteEn), 64'(v.e_we));
            chk($sformatf("%s memAddr", tag), memAddr, v.e_addr);
            if (v.e_we) chk($sformatf("%s memWData", tag), memWData, v.e_wdata);
         end
         if (fetchAck || dataAck) begin
            got = 1'b1;
            chk($sformatf("%s latency", tag), 64'(k), 64'(v.e_lat));
            chk($sformatf("%s fetchAck", tag), 64'(fetchAck), 64'(v.e_owner == OWNER_FETCH));
            chk($sformatf("%s dataAck", tag), 64'(dataAck), 64'(v.e_owner == OWNER_DATA));
            chk($sformatf("%s busErr", tag), 64'(busErr), 64'(v.e_berr));
            chk($sformatf("%s fetchData", tag), 64'(fetchData), 64'(v.e_fdata));
            chk($sformatf("%s dataRData", tag), dataRData, v.e_drdata);
            chk($sformatf("%s memEnable@ack", tag), 64'(memEnable), 64'(0));
            fetchReq = 1'b0; dataReq = 1'b0; memReady = 1'b0;
         end else if (memEnable) begin
            acc++;
            memReady = (acc > v.delay);
         end
      end
      if (!got) begin
         n_cmp++; n_fail++;
         $display("FAIL %s: no ack within 600 cycles", tag);
         fetchReq = 1'b0; dataReq = 1'b0; memReady = 1'b0;
      end
      @(negedge clock);
      chk($sformatf("%s ack pulse width", tag), 64'({fetchAck, dataAck}), 64'(0));
      chk($sformatf("%s busy after", tag), 64'(busy), 64'(0));
   endtask

   // Both requesters held high; data may take MAXS grants before fetch is forced
   task automatic streak_seq();
      logic got;
      logic exp_owner;
      @(negedge clock);
      fetchReq = 1'b1; fetchAddr = 64'h80;
      dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 64'h600;
      for (int g = 0; g < 10; g++) begin
         exp_owner = ((g % (MAXS + 1)) == MAXS) ? OWNER_FETCH : OWNER_DATA;
         got = 1'b0;
         for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clock);
            if (memEnable) got = 1'b1;
         end
         if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL streak grant %0d: no memEnable", g);
         end
         chk($sformatf("streak grant %0d owner", g), 64'(owner), 64'(exp_owner));
         memReady = 1'b1; memRData = 64'(g);
         @(negedge clock);
         memReady = 1'b0;
         chk($sformatf("streak grant %0d acks", g), 64'({fetchAck, dataAck}),
             64'({exp_owner == OWNER_FETCH, exp_owner == OWNER_DATA}));
      end
      fetchReq = 1'b0; dataReq = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   // Reset lands while a store is waiting on memory
   task automatic reset_mid_access();
      @(negedge clock);
      dataReq = 1'b1; dataWrite = 1'b1; dataAddr = 64'h500; dataWData = 64'h77;
      memReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("rstmid memEnable before", 64'(memEnable), 64'(1));
         chk("rstmid dataAck before", 64'(dataAck), 64'(0));
      end
      #2;
      resetN = 1'b0;
      dataReq = 1'b0;
      #1;
      chk("rstmid memEnable", 64'(memEnable), 64'(0));
      chk("rstmid busy", 64'(busy), 64'(0));
      chk("rstmid owner", 64'(owner), 64'(OWNER_FETCH));
      chk("rstmid memWriteEn", 64'(memWriteEn), 64'(0));
      repeat (2) @(negedge clock);
      resetN = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         chk("rstmid dataAck after", 64'(dataAck), 64'(0));
         chk("rstmid busy after", 64'(busy), 64'(0));
      end
      apply_vec("rstmid fetch", mk(1, 0, 0, 64'h60, 0, 0, 64'h0000_0000_FEED_F00D, 1,
                OWNER_FETCH, 0, 64'h60, 0, 32'hFEED_F00D, 64'h0, 3, 0));
   endtask

   // Free-running requesters and memory, checked against a transaction-level model
   task automatic run_random(input int ncyc);
      int          ph, acc, dly, streak;
      logic        f_pend, d_pend, d_wr;
      logic [63:0] f_addr, d_addr, d_wd;
      logic        e_busy, e_men, e_fack, e_dack, e_grant;
      logic        g_data, g_we;
      logic [63:0] g_addr, g_wd, g_rd;
      logic [31:0] m_fd;
      logic [63:0] m_dr;
      ph = 0; acc = 0; dly = 0; streak = 0;
      f_pend = 0; d_pend = 0; d_wr = 0; f_addr = 0; d_addr = 0; d_wd = 0;
      e_busy = 0; e_men = 0; e_fack = 0; e_dack = 0; e_grant = 0;
      g_data = 0; g_we = 0; g_addr = 0; g_wd = 0; g_rd = 0; m_fd = 0; m_dr = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clock);
         chk("rnd busy", 64'(busy), 64'(e_busy));
         chk("rnd memEnable", 64'(memEnable), 64'(e_men));
         chk("rnd fetchAck", 64'(fetchAck), 64'(e_fack));
         chk("rnd dataAck", 64'(dataAck), 64'(e_dack));
         if (e_fack || e_dack) begin
            chk("rnd busErr", 64'(busErr), 64'(0));
            chk("rnd fetchData", 64'(fetchData), 64'(m_fd));
            chk("rnd dataRData", dataRData, m_dr);
         end
         if (e_grant) begin
            chk("rnd owner", 64'(owner), 64'(g_data));
            chk("rnd memAddr", memAddr, g_addr);
            chk("rnd memWriteEn", 64'(memWriteEn), 64'(g_we));
            if (g_we) chk("rnd memWData", memWData, g_wd);
         end
         if (e_fack) f_pend = 1'b0;
         if (e_dack) d_pend = 1'b0;
         if (!f_pend && $urandom_range(0, 3) != 0) begin
            f_pend = 1'b1;
            f_addr = {$urandom, $urandom} & ~64'h3;
         end
         if (!d_pend && $urandom_range(0, 3) != 0) begin
            d_pend = 1'b1;
            d_wr   = 1'($urandom_range(0, 1));
            d_addr = {$urandom, $urandom} & ~64'h7;
            d_wd   = {$urandom, $urandom};
         end
         fetchReq = f_pend; fetchAddr = f_addr;
         dataReq = d_pend; dataWrite = d_wr; dataAddr = d_addr; dataWData = d_wd;
         if (ph == 1) begin
            acc++;
            memReady = (acc > dly);
            memRData = g_rd;
         end else begin
            memReady = 1'($urandom_range(0, 1));
            memRData = {$urandom, $urandom};
         end
         e_grant = 1'b0; e_fack = 1'b0; e_dack = 1'b0;
         case (ph)
            0: begin
               if (f_pend || d_pend) begin
                  g_data = d_pend && !(f_pend && streak == int'(MAXS));
                  if (f_pend && g_data) streak = (streak < int'(MAXS)) ? streak + 1 : streak;
                  else streak = 0;
                  g_we   = g_data && d_wr;
                  g_addr = g_data ? d_addr : f_addr;
                  g_wd   = d_wd;
                  g_rd   = {$urandom, $urandom};
                  dly    = $urandom_range(0, 4);
                  acc    = 0;
                  ph     = 1;
                  e_men = 1'b1; e_busy = 1'b1; e_grant = 1'b1;
               end else begin
                  streak = 0;
                  e_men = 1'b0; e_busy = 1'b0;
               end
            end
            1: begin
               if (memReady) begin
                  ph = 2;
                  e_men = 1'b0; e_busy = 1'b1;
                  if (g_data) begin
                     e_dack = 1'b1;
                     if (!g_we) m_dr = g_rd;
                  end else begin
                     e_fack = 1'b1;
                     m_fd = g_rd[31:0];
                  end
               end else begin
                  e_men = 1'b1; e_busy = 1'b1;
               end
            end
            default: begin
               ph = 0;
               e_men = 1'b0; e_busy = 1'b0;
            end
         endcase
      end
      idle_inputs();
   endtask

   initial begin
      resetN = 1'b0;
      idle_inputs();

      tv[0] = mk(1, 0, 0, 64'h40, 0, 0, 64'h1234_5678_8B02_0020, 0,
                 OWNER_FETCH, 0, 64'h40, 0, 32'h8B02_0020, 64'h0, 2, 0);
      tv[1] = mk(0, 1, 0, 0, 64'h200, 0, 64'hCAFE_F00D_0000_1111, 1,
                 OWNER_DATA, 0, 64'h200, 0, 32'h8B02_0020, 64'hCAFE_F00D_0000_1111, 3, 0);
      tv[2] = mk(0, 1, 1, 0, 64'h100, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, 0,
                 OWNER_DATA, 1, 64'h100, 64'hDEAD, 32'h8B02_0020, 64'hCAFE_F00D_0000_1111, 2, 0);
      tv[3] = mk(1, 1, 1, 64'h44, 64'h108, 64'hBEEF, 64'h5555_5555_5555_5555, 2,
                 OWNER_DATA, 1, 64'h108, 64'hBEEF, 32'h8B02_0020, 64'hCAFE_F00D_0000_1111, 4, 0);
      tv[4] = mk(1, 0, 0, 64'h48, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 3,
                 OWNER_FETCH, 0, 64'h48, 0, 32'hCCCC_DDDD, 64'hCAFE_F00D_0000_1111, 5, 0);
      tv[5] = mk(1, 1, 0, 64'h4C, 64'h300, 0, 64'h0123_4567_89AB_CDEF, 0,
                 OWNER_DATA, 0, 64'h300, 0, 32'hCCCC_DDDD, 64'h0123_4567_89AB_CDEF, 2, 0);
      tv[6] = mk(0, 1, 0, 0, 64'h308, 0, 64'h9999_9999_9999_9999, 999,
                 OWNER_DATA, 0, 64'h308, 0, 32'hCCCC_DDDD, 64'h0, 256, 1);
      tv[7] = mk(1, 0, 0, 64'h50, 0, 0, 64'h9999_9999_9999_9999, 999,
                 OWNER_FETCH, 0, 64'h50, 0, 32'h0, 64'h0, 256, 1);
      tv[8] = mk(1, 0, 0, 64'h54, 0, 0, 64'h0000_0000_1357_9BDF, 0,
                 OWNER_FETCH, 0, 64'h54, 0, 32'h1357_9BDF, 64'h0, 2, 0);

      // Outputs while reset is held
      repeat (2) @(negedge clock);
      chk("reset memEnable", 64'(memEnable), 64'(0));
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset owner", 64'(owner), 64'(0));
      chk("reset acks", 64'({fetchAck, dataAck, busErr}), 64'(0));
      chk("reset memWriteEn", 64'(memWriteEn), 64'(0));
      chk("reset memAddr", memAddr, 64'h0);
      chk("reset memWData", memWData, 64'h0);
      chk("reset fetchData", 64'(fetchData), 64'(0));
      chk("reset dataRData", dataRData, 64'h0);
      @(negedge clock);
      resetN = 1'b1;

      for (int i = 0; i < 9; i++) begin
         apply_vec($sformatf("vec%0d", i), tv[i]);
      end

      do_reset();
      streak_seq();

      reset_mid_access();

      do_reset();
      run_random(1500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-cache/memory port between instruction fetch and load/store (memRead/memWrite) traffic.
- Grants one requester at a time, sequences the access over a variable-latency memory handshake, and returns data to that requester with a one-cycle ack pulse.
- Data accesses have priority so the pipeline can drain; a streak limit prevents fetch starvation.
- A timeout aborts accesses to a hung memory.

Parameters:
ADDR_WIDTH, 64, byte address width for both requesters and the memory port
DATA_WIDTH, 64, memory data width; fetch returns the low 32 bits
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced
TIMEOUT, 255, ACCESS cycles without memReady before the access is aborted (must be >= 1)

Ports:
clock  in  1  main clock; all state changes on posedge
resetN  in  1  asynchronous active-low reset
fetchReq  in  1  instruction fetch request
fetchAddr  in  ADDR_WIDTH  fetch address
fetchAck  out  1  one-cycle pulse: fetchData valid
fetchData  out  32  fetched instruction
dataReq  in  1  load/store request
dataWrite  in  1  1 = store, 0 = load
dataAddr  in  ADDR_WIDTH  load/store address
dataWData  in  DATA_WIDTH  store data
dataAck  out  1  one-cycle pulse: load data valid / store complete
dataRData  out  DATA_WIDTH  load data
busErr  out  1  high together with the ack of an access aborted by timeout
memEnable  out  1  memory access in progress
memWriteEn  out  1  write qualifier, valid while memEnable is high
memAddr  out  ADDR_WIDTH  latched access address
memWData  out  DATA_WIDTH  latched store data
memRData  in  DATA_WIDTH  memory read data, sampled with memReady
memReady  in  1  memory completion, sampled only in ACCESS
owner  out  1  0 = fetch, 1 = data; current or most recent grant
busy  out  1  high in ACCESS and RESPOND

Behaviour:
- Reset (resetN low, asynchronous):
  - All outputs are 0. FSM goes to IDLE. Streak and timeout counters are cleared.
  - An access in flight is dropped with no ack; requesters must re-present their request after reset.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - With any request sampled high: grant, latch address/write/wdata into memAddr/memWriteEn/memWData, set owner, go to ACCESS.
  - memEnable rises in the cycle after the request is sampled.
  - With no request: stay in IDLE; memEnable stays 0.
- Arbitration (IDLE only):
  - Data only -> data. Fetch only -> fetch.
  - Both requesting -> data, unless streak == MAX_DATA_STREAK, in which case fetch wins.
  - Streak counter: increments on a data grant while fetchReq is high; clears on a fetch grant or when fetchReq is low in IDLE; saturates at MAX_DATA_STREAK.
- ACCESS:
  - memEnable = 1; memAddr, memWriteEn and memWData are held stable.
  - On memReady: capture memRData into the owner's data register and go to RESPOND.
  - Timeout counter increments each ACCESS cycle. On reaching TIMEOUT without memReady: go to RESPOND with busErr set; read data is forced to 0.
  - memReady and timeout in the same cycle: memReady wins and busErr = 0.
- RESPOND:
  - memEnable = 0. The owner's ack = 1 for exactly this cycle; busErr is valid this cycle.
  - Always returns to IDLE next cycle; the timeout counter clears.
- Latency: request sampled at edge N -> ACCESS from N+1 -> memReady sampled at edge M -> ack high in cycle M+1. Minimum request-to-ack latency is 2 cycles (memReady already high in the first ACCESS cycle).
- Handshake rules:
  - Requesters hold req, address and data stable until their ack, then deassert req at the ack edge.
  - A req still high in the IDLE cycle after RESPOND is treated as a new request.
  - Inputs are latched at grant, so changes after grant do not affect the access.
- The non-owner's req is ignored until IDLE. memReady outside ACCESS is ignored.
- fetchData/dataRData hold their last value between acks. Loads update dataRData; stores leave it unchanged.
- Back-to-back accesses: one IDLE cycle between RESPOND and the next ACCESS (3-cycle minimum period).

Decomposition:
- Shared header (guarded with `ifndef`): state encodings (IDLE = 0, ACCESS = 1, RESPOND = 2) and owner codes (OWNER_FETCH = 0, OWNER_DATA = 1), so the pipeline and the bench decode owner consistently.
- One natural sub-module: arb_streak_counter (saturating counter with increment/clear/limit-reached output), reusable for other shared ports.
- Timeout counter stays inline.

Test Plan:
- Reset is asserted mid-ACCESS (data store, memReady held 0) -> in the same cycle memEnable = 0, busy = 0 and owner = 0; no dataAck ever fires; after release, a new fetchReq is granted normally.
- fetchReq alone, addr 0x40, memReady high in the first ACCESS cycle with memRData = 0x1234_5678_8B02_0020 -> fetchAck pulses 2 cycles after the request with fetchData = 0x8B020020; memWriteEn = 0 throughout.
- fetchReq and dataReq high together, dataWrite = 1, addr 0x100, wdata 0xDEAD -> data is granted first: memWriteEn = 1, memAddr = 0x100, memWData = 0xDEAD; dataAck pulses; then fetch is served after one IDLE cycle.
- fetchReq held high while dataReq is re-asserted after every ack, MAX_DATA_STREAK = 4 -> 4 data grants, then the 5th grant goes to fetch (owner = 0), and the streak counter clears.
- dataReq load, memReady never asserted, TIMEOUT = 255 -> dataAck and busErr both high exactly 256 cycles after the request, dataRData = 0, FSM back in IDLE.
- memReady pulsed while in IDLE and RESPOND -> no ack and no state change; only memReady during ACCESS completes an access.
